// File: rtl/pulse_conditioner.sv
// Trigger synchronizer, glitch filter and burst-limited pulse shaper for the divider.
// Optional missed-edge counter enabled by defining PULSE_COND_MISS_COUNT_EN.
module pulse_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int PULSE_WIDTH   = 4,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     sample_clock,
    input  logic                     external_reset,
    input  logic                     raw_trigger,
    input  logic                     arm,
    input  logic [COUNT_WIDTH-1:0]   burst_target,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles,
    output logic                     conditioned_pulse,
    output logic                     divider_enable,
    output logic                     burst_done,
    output logic [COUNT_WIDTH-1:0]   pulse_count
`ifdef PULSE_COND_MISS_COUNT_EN
    ,
    output logic [15:0]              missed_count
`endif
);

    localparam int FW  = $clog2(FILTER_CYCLES + 1);
    localparam int PWW = $clog2(PULSE_WIDTH + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ARMED      = 3'd1;
    localparam logic [2:0] PULSE_HIGH = 3'd2;
    localparam logic [2:0] HOLDOFF    = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [FW-1:0]            filt_q, filt_d;
    logic [2:0]               state_q, state_d;
    logic [PWW-1:0]           pw_q, pw_d;
    logic [HOLDOFF_WIDTH-1:0] ho_q, ho_d;
    logic [COUNT_WIDTH-1:0]   bt_q, bt_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic                     drop_q, drop_d;
    logic                     sync_out;
    logic                     accept;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw_trigger};

    // Count saturates at FILTER_CYCLES so a held-high input is accepted once
    always_comb begin
        filt_d = filt_q;
        if (!sync_out) begin
            filt_d = '0;
        end else if (filt_q != FW'(FILTER_CYCLES)) begin
            filt_d = filt_q + FW'(1);
        end
    end

    assign accept = sync_out && (filt_q == FW'(FILTER_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        ho_d    = ho_q;
        bt_d    = bt_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    bt_d    = burst_target;
                end
            end
            ARMED: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = PULSE_HIGH;
                    pw_d    = '0;
                    drop_d  = 1'b0;
                    if (cnt_q != {COUNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                    end
                end
            end
            PULSE_HIGH: begin
                pw_d = pw_q + PWW'(1);
                if (!arm) begin
                    drop_d = 1'b1;
                end
                // Width always completes; an arm drop is honoured afterwards
                if (pw_q == PWW'(PULSE_WIDTH - 1)) begin
                    if (drop_q || !arm) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLDOFF;
                        ho_d    = holdoff_cycles;
                    end
                end
            end
            HOLDOFF: begin
                if (!arm) begin
                    state_d = IDLE;
                end else if (ho_q <= HOLDOFF_WIDTH'(1)) begin
                    if ((bt_q != '0) && (cnt_q == bt_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ARMED;
                        bt_d    = burst_target;
                    end
                end else begin
                    ho_d = ho_q - HOLDOFF_WIDTH'(1);
                end
            end
            DONE: begin
                if (!arm) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sample_clock) begin
        if (external_reset) begin
            sync_q  <= '0;
            filt_q  <= '0;
            state_q <= IDLE;
            pw_q    <= '0;
            ho_q    <= '0;
            bt_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            filt_q  <= filt_d;
            state_q <= state_d;
            pw_q    <= pw_d;
            ho_q    <= ho_d;
            bt_q    <= bt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign conditioned_pulse = (state_q == PULSE_HIGH);
    assign divider_enable    = (state_q == ARMED) || (state_q == PULSE_HIGH) ||
                               (state_q == HOLDOFF);
    assign burst_done        = done_q;
    assign pulse_count       = cnt_q;

`ifdef PULSE_COND_MISS_COUNT_EN
    logic [15:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if ((state_q == IDLE) && arm) begin
            miss_d = '0;
        end else if (accept && arm && (miss_q != 16'hFFFF) &&
                     ((state_q == PULSE_HIGH) || (state_q == HOLDOFF))) begin
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge sample_clock) begin
        if (external_reset) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign missed_count = miss_q;
`endif

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed self-checking bench for pulse_conditioner.
// Covers latency, glitch rejection, burst limit, holdoff, arm drop and reset.
module tb_pulse_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        raw;
    logic        arm;
    logic [31:0] bt;
    logic [15:0] ho;
    logic        cp;
    logic        en;
    logic        done;
    logic [31:0] cnt;
`ifdef PULSE_COND_MISS_COUNT_EN
    logic [15:0] missed;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic prev_cp = 1'b0;

    always #5 clk = ~clk;

    pulse_conditioner dut (
        .sample_clock      (clk),
        .external_reset    (rst),
        .raw_trigger       (raw),
        .arm               (arm),
        .burst_target      (bt),
        .holdoff_cycles    (ho),
        .conditioned_pulse (cp),
        .divider_enable    (en),
        .burst_done        (done),
        .pulse_count       (cnt)
`ifdef PULSE_COND_MISS_COUNT_EN
        ,
        .missed_count      (missed)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (cp && !prev_cp) pulses++;
        prev_cp = cp;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; raw = 1'b0; arm = 1'b0; bt = 0; ho = 0;
        repeat (3) tick();
        chk("rst_pulse", cp, 0);
        chk("rst_en", en, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);

        // Basic latency and width
        rst = 1'b0; arm = 1'b1;
        tick();
        chk("arm_en", en, 1);
        raw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 10) raw = 1'b0;
            chk($sformatf("t1_pulse_%0d", i), cp, (i >= 5 && i <= 8));
        end
        repeat (5) tick();
        chk("t1_cnt", cnt, 1);
        chk("t1_en", en, 1);

        // Short glitch rejected
        arm = 1'b0;
        tick();
        chk("t2_idle_en", en, 0);
        arm = 1'b1;
        tick();
        chk("t2_cnt_clr", cnt, 0);
        pulses = 0;
        raw = 1'b1;
        repeat (2) tick();
        raw = 1'b0;
        repeat (12) tick();
        chk("t2_pulses", pulses, 0);
        chk("t2_cnt", cnt, 0);

        // Burst of three
        arm = 1'b0; bt = 3; ho = 5;
        tick();
        arm = 1'b1;
        tick();
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            raw = 1'b1;
            repeat (4) tick();
            raw = 1'b0;
            repeat (16) tick();
        end
        chk("t3_pulses", pulses, 3);
        chk("t3_cnt", cnt, 3);
        chk("t3_done", done, 1);
        chk("t3_en", en, 0);
        arm = 1'b0;
        tick();
        chk("t3_idle_done", done, 1);
        chk("t3_idle_en", en, 0);
        arm = 1'b1;
        tick();
        chk("t3_rearm_done", done, 0);
        chk("t3_rearm_cnt", cnt, 0);

        // Long holdoff swallows second trigger
        arm = 1'b0; bt = 0; ho = 50;
        tick();
        arm = 1'b1;
        tick();
        pulses = 0;
        raw = 1'b1;
        repeat (4) tick();
        raw = 1'b0;
        repeat (16) tick();
        raw = 1'b1;
        repeat (4) tick();
        raw = 1'b0;
        repeat (56) tick();
        chk("t4_pulses", pulses, 1);
        chk("t4_cnt", cnt, 1);
`ifdef PULSE_COND_MISS_COUNT_EN
        chk("t4_missed", missed, 1);
`endif

        // Arm drop during the pulse
        arm = 1'b0; ho = 0;
        tick();
        arm = 1'b1;
        tick();
        raw = 1'b1;
        repeat (6) tick();
        chk("t5_pulse_c2", cp, 1);
        arm = 1'b0;
        tick();
        chk("t5_pulse_c3", cp, 1);
        chk("t5_en_c3", en, 1);
        tick();
        chk("t5_pulse_c4", cp, 1);
        tick();
        chk("t5_pulse_end", cp, 0);
        chk("t5_en_end", en, 0);
        raw = 1'b0;
        tick();
        chk("t5_en_idle", en, 0);
        chk("t5_cnt", cnt, 1);

        // Reset in holdoff, then normal operation
        ho = 50; arm = 1'b1;
        repeat (4) tick();
        raw = 1'b1;
        repeat (4) tick();
        raw = 1'b0;
        repeat (8) tick();
        chk("t6_holdoff_en", en, 1);
        chk("t6_holdoff_cp", cp, 0);
        rst = 1'b1;
        tick();
        chk("t6_rst_cp", cp, 0);
        chk("t6_rst_en", en, 0);
        chk("t6_rst_cnt", cnt, 0);
        chk("t6_rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("t6_rearm_en", en, 1);
        repeat (3) tick();
        raw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("t6_pulse_%0d", i), cp, (i >= 5 && i <= 8));
        end
        raw = 1'b0;
        chk("t6_cnt", cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
